// File: rtl/user_output_leds_if.sv
// Avalon-MM bus bundle for the user_output_leds peripheral.
//   avs_address        word address (3 bits)
//   avs_read           single-cycle read strobe
//   avs_write          single-cycle write strobe
//   avs_writedata      32-bit write data
//   avs_readdata       32-bit read data, valid with avs_readdatavalid
//   avs_readdatavalid  one-cycle pulse, fixed read latency 1
// master: the HPS lightweight bridge side; slave: the LED peripheral.
interface user_output_leds_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/user_output_leds.sv
// HPS-writable LED driver: per LED static level, blinking and timed one-shot
// pulses, all timed from a millisecond prescaler.
//   clk    system clock (CLOCK_50 domain)
//   reset  synchronous, active-high
//   avs    Avalon-MM slave (user_output_leds_if.slave), no waitrequest
//   leds   registered LED drive, 1 = on
// Register map (word address):
//   0 OUT   R/W static level        1 BMASK R/W blinking LEDs
//   2 BHALF R/W blink half-period ms (0 = off)
//   3 PULSE W: [N-1:0] mask, [31:16] duration ms; R: active mask, ms left
//   4 ID    RO 0x4C45_0000 | NUM_LEDS; 5-7 read 0
module user_output_leds #(
  parameter int NUM_LEDS = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                reset,
  user_output_leds_if.slave   avs,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
  localparam logic [31:0]   ID_WORD  = 32'h4C45_0000 | 32'(NUM_LEDS);

  logic [NUM_LEDS-1:0] out_r;
  logic [NUM_LEDS-1:0] bmask_r;
  logic [15:0]         bhalf_r;
  logic [15:0]         bcnt_r;
  logic                phase_r;
  logic [NUM_LEDS-1:0] pmask_r;
  logic [15:0]         prem_r;
  logic [PW-1:0]       pcnt_r;
  logic                tick;
  logic [31:0]         rd_mux;
  logic                wr_out, wr_bmask, wr_bhalf, wr_pulse;
  logic [15:0]         wr_dur;

  assign tick     = (pcnt_r == PCNT_MAX);
  assign wr_out   = avs.avs_write && (avs.avs_address == 3'd0);
  assign wr_bmask = avs.avs_write && (avs.avs_address == 3'd1);
  assign wr_bhalf = avs.avs_write && (avs.avs_address == 3'd2);
  assign wr_pulse = avs.avs_write && (avs.avs_address == 3'd3);
  assign wr_dur   = avs.avs_writedata[31:16];

  // Read mux sees register state before any same-cycle write.
  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      3'd0:    rd_mux = 32'(out_r);
      3'd1:    rd_mux = 32'(bmask_r);
      3'd2:    rd_mux = {16'd0, bhalf_r};
      3'd3:    rd_mux = {prem_r, 16'(pmask_r)};
      3'd4:    rd_mux = ID_WORD;
      default: rd_mux = '0;
    endcase
  end

  // Free-running ms prescaler; writes never disturb it.
  always_ff @(posedge clk) begin
    if (reset) pcnt_r <= '0;
    else       pcnt_r <= tick ? '0 : pcnt_r + 1'b1;
  end

  // Static level and blink mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r   <= '0;
      bmask_r <= '0;
    end else begin
      if (wr_out)   out_r   <= avs.avs_writedata[NUM_LEDS-1:0];
      if (wr_bmask) bmask_r <= avs.avs_writedata[NUM_LEDS-1:0];
    end
  end

  // Blink engine: a BHALF write restarts the half-period from phase 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bhalf_r <= '0;
      bcnt_r  <= '0;
      phase_r <= 1'b0;
    end else if (wr_bhalf) begin
      bhalf_r <= avs.avs_writedata[15:0];
      bcnt_r  <= '0;
      phase_r <= 1'b0;
    end else if (tick && (bhalf_r != 16'd0)) begin
      if (bcnt_r == bhalf_r - 16'd1) begin
        bcnt_r  <= '0;
        phase_r <= ~phase_r;
      end else begin
        bcnt_r <= bcnt_r + 16'd1;
      end
    end
  end

  // Pulse engine: a write always overrides the tick in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pmask_r <= '0;
      prem_r  <= '0;
    end else if (wr_pulse) begin
      if (wr_dur != 16'd0) begin
        pmask_r <= avs.avs_writedata[NUM_LEDS-1:0];
        prem_r  <= wr_dur;
      end else begin
        pmask_r <= '0;
        prem_r  <= '0;
      end
    end else if (tick && (prem_r != 16'd0)) begin
      prem_r <= prem_r - 16'd1;
      if (prem_r == 16'd1) pmask_r <= '0;
    end
  end

  // Output stage: LED drive and read response, both one edge after state.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds                  <= '0;
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      leds                  <= (out_r ^ (bmask_r & {NUM_LEDS{phase_r}})) | pmask_r;
      avs.avs_readdatavalid <= avs.avs_read;
      if (avs.avs_read) avs.avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_user_output_leds.sv
module tb_user_output_leds;
  localparam int N = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] leds;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  user_output_leds_if bus ();

  user_output_leds #(.NUM_LEDS(N), .PRESCALE(P)) dut (
    .clk   (clk),
    .reset (reset),
    .avs   (bus.slave),
    .leds  (leds)
  );

  // Behavioural model: time is counted in ms ticks; blink phase and pulse
  // remaining are derived from the tick count at which they were programmed.
  logic         m_ready = 1'b0;
  int           m_edges, m_ticks, m_bstart, m_pend, m_bhalf;
  logic [N-1:0] m_out, m_bmask, m_pmask;
  logic [N-1:0] exp_leds;
  logic         exp_rdv;
  logic [31:0]  exp_rd;

  function automatic int m_prem();
    return (m_pend > m_ticks) ? (m_pend - m_ticks) : 0;
  endfunction

  function automatic logic m_phase();
    if (m_bhalf == 0) return 1'b0;
    return (((m_ticks - m_bstart) / m_bhalf) % 2) == 1;
  endfunction

  function automatic logic [N-1:0] m_active_mask();
    return (m_prem() != 0) ? m_pmask : '0;
  endfunction

  function automatic logic [N-1:0] m_leds();
    return (m_out ^ (m_bmask & {N{m_phase()}})) | m_active_mask();
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_out);
      3'd1:    return 32'(m_bmask);
      3'd2:    return 32'(m_bhalf);
      3'd3:    return {16'(m_prem()), 16'(m_active_mask())};
      3'd4:    return 32'h4C45_0004;
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_ready = 1'b1;
      m_edges = 0; m_ticks = 0; m_bstart = 0; m_pend = 0; m_bhalf = 0;
      m_out = '0; m_bmask = '0; m_pmask = '0;
      exp_leds = '0; exp_rdv = 1'b0; exp_rd = '0;
    end else if (m_ready) begin
      exp_leds = m_leds();
      exp_rdv  = bus.avs_read;
      if (bus.avs_read) exp_rd = m_read(bus.avs_address);
      if ((m_edges % P) == P - 1) m_ticks++;
      m_edges++;
      if (bus.avs_write) begin
        case (bus.avs_address)
          3'd0: m_out   = bus.avs_writedata[N-1:0];
          3'd1: m_bmask = bus.avs_writedata[N-1:0];
          3'd2: begin m_bhalf = int'(bus.avs_writedata[15:0]); m_bstart = m_ticks; end
          3'd3: begin
            if (bus.avs_writedata[31:16] != 16'd0) begin
              m_pmask = bus.avs_writedata[N-1:0];
              m_pend  = m_ticks + int'(bus.avs_writedata[31:16]);
            end else begin
              m_pmask = '0;
              m_pend  = m_ticks;
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      check("model_leds", 32'(leds), 32'(exp_leds));
      check("model_rdv", 32'(bus.avs_readdatavalid), 32'(exp_rdv));
      if (exp_rdv) check("model_rdata", bus.avs_readdata, exp_rd);
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] req);
    rd(a);
    check({nm, "_rdv"}, 32'(bus.avs_readdatavalid), 32'd1);
    check(nm, bus.avs_readdata, req);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] id_tab [5];
    int          cnt, t0, t1;
    logic        prev;
    id_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4C45_0004};
    reset = 1'b1;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state and register readback
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_rdv", 32'(bus.avs_readdatavalid), 32'h0);
    for (int a = 0; a < 5; a++) rd_chk("rst_reg", 3'(a), id_tab[a]);

    // 2: static level, unmapped write, read-during-write
    wr(3'd0, 32'hFFFF_FFFA);
    check("out_lag", 32'(leds), 32'h0);
    @(negedge clk);
    check("out_leds", 32'(leds), 32'hA);
    rd_chk("out_rd", 3'd0, 32'h0000_000A);
    wr(3'd6, 32'hFFFF_FFFF);
    rd_chk("unmapped_wr", 3'd0, 32'h0000_000A);
    rd_chk("unmapped_rd", 3'd6, 32'h0);
    bus.avs_address = 3'd0; bus.avs_writedata = 32'h5;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    check("rw_same_cycle", bus.avs_readdata, 32'h0000_000A);
    rd_chk("rw_after", 3'd0, 32'h5);
    wr(3'd0, 32'h0);

    // 3: blink period and disable
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h2);
    rd_chk("bhalf_rd", 3'd2, 32'h2);
    prev = leds[0]; t0 = -1; t1 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (leds[0] !== prev) begin
        prev = leds[0];
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
    end
    check("blink_period", 32'(t1 - t0), 32'd8);
    wr(3'd2, 32'h0);
    repeat (12) @(negedge clk);
    check("blink_off", 32'(leds), 32'h0);
    wr(3'd1, 32'h0);

    // 4: timed pulse length and ms-left readback
    wr(3'd0, 32'h1);
    wr(3'd3, {16'd3, 16'h8});
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (leds === 4'h9) cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt < 9 || cnt > 12) begin
      failures++;
      $display("FAIL pulse_len actual=%0d required=9..12", cnt);
    end
    check("pulse_done", 32'(leds), 32'h1);
    wr(3'd3, {16'd3, 16'h8});
    rd_chk("prem_first", 3'd3, 32'h0003_0008);
    repeat (16) rd(3'd3);
    rd_chk("prem_last", 3'd3, 32'h0);

    // 5: cancel, and write landing on a tick edge
    wr(3'd3, {16'd10, 16'h8});
    repeat (3) @(negedge clk);
    check("pulse_on", 32'(leds), 32'h9);
    wr(3'd3, 32'h0);
    @(negedge clk);
    check("pulse_cancel", 32'(leds), 32'h1);
    for (int i = 0; i < P + 1 && (m_edges % P) != P - 1; i++) @(negedge clk);
    wr(3'd3, {16'd5, 16'h2});
    rd_chk("write_wins_tick", 3'd3, 32'h0005_0002);

    // 6: reset aborts everything
    wr(3'd0, 32'hF);
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h1);
    wr(3'd3, {16'd20, 16'h4});
    repeat (5) @(negedge clk);
    pulse_reset();
    check("rst2_leds", 32'(leds), 32'h0);
    for (int a = 0; a < 4; a++) rd_chk("rst2_reg", 3'(a), 32'h0);
    repeat (20) @(negedge clk);
    check("rst2_idle", 32'(leds), 32'h0);
    wr(3'd1, 32'h3);
    wr(3'd2, 32'h1);
    repeat (16) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
